rmt_tx_deparser: RTL and testbench

RMT_TX_DEPARSER -- requirements
Module: rmt_tx_deparser

---
 rtl/rmt_tx_deparser_if.sv | 17 +
 rtl/rmt_tx_deparser.sv | 168 ++++++++++++++++
 tb/tb_rmt_tx_deparser.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rmt_tx_deparser_if.sv
// AXI-Stream bundle used on both sides of rmt_tx_deparser.
// master drives the payload and valid, slave drives tready.
interface rmt_tx_deparser_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/rmt_tx_deparser.sv
// rmt_tx_deparser: turns a function-unit response frame into a reply frame
// toward MAC TX. The first beat has MAC/IPv4/UDP source and destination
// swapped, the UDP checksum cleared and the response tag written. Frames
// with a bad EtherType/delimiter or a short first beat are dropped.
// Optional feature macro: RMT_TX_STATS_EN enables the frame/drop counters;
// without it both counters read zero.
module rmt_tx_deparser #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rmt_tx_deparser_if.slave     s_axis,
    input  logic [15:0]          s_axis_tid,
    rmt_tx_deparser_if.master    m_axis,
    output logic [31:0]          stat_frames,
    output logic [31:0]          stat_drops
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                state_reg;
    logic                  m_valid_reg;
    logic                  m_last_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;
    logic [KEEP_WIDTH-1:0] m_keep_reg;
    logic [USER_WIDTH-1:0] m_user_reg;

    logic                  s_ready;
    logic                  s_accept;
    logic                  first_ok;
    logic [15:0]           tid_flag;
    wire  [DATA_WIDTH-1:0] rw_data;

    // Source byte for each output byte of a rewritten first beat:
    // MAC, IPv4 address and UDP port pairs trade places.
    function automatic int src_byte(input int b);
        if (b <= 5)                 return b + 6;
        else if (b <= 11)           return b - 6;
        else if (b >= 26 && b <= 29) return b + 4;
        else if (b >= 30 && b <= 33) return b - 4;
        else if (b >= 34 && b <= 35) return b + 2;
        else if (b >= 36 && b <= 37) return b - 2;
        else                         return b;
    endfunction

    // DROP sinks everything; otherwise accept only when the output slot frees up.
    assign s_ready  = !rst && ((state_reg == ST_DROP) || !m_valid_reg || m_axis.tready);
    assign s_accept = s_axis.tvalid && s_ready;

    // Header sanity: IPv4 EtherType, RMT delimiter, and all header bytes present.
    assign first_ok = (s_axis.tdata[12*8 +: 16] == 16'h0008) &&
                      (s_axis.tdata[42*8 +: 16] == 16'hF0E1) &&
                      (&s_axis.tkeep[45:0]);

    assign tid_flag = s_axis_tid | 16'h8000;

    // Per-byte rewrite of the first beat.
    genvar gi;
    generate
        for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_rw
            if (gi == 40 || gi == 41) begin : g_csum
                assign rw_data[gi*8 +: 8] = 8'h00;
            end else if (gi == 44) begin : g_flag_lo
                assign rw_data[gi*8 +: 8] = tid_flag[7:0];
            end else if (gi == 45) begin : g_flag_hi
                assign rw_data[gi*8 +: 8] = tid_flag[15:8];
            end else begin : g_copy
                localparam int SRC = src_byte(gi);
                assign rw_data[gi*8 +: 8] = s_axis.tdata[SRC*8 +: 8];
            end
        end
    endgenerate

    // Frame FSM plus the single output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            m_data_reg  <= '0;
            m_keep_reg  <= '0;
            m_user_reg  <= '0;
        end else begin
            if (m_valid_reg && m_axis.tready) begin
                m_valid_reg <= 1'b0;
            end
            if (s_accept) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (first_ok) begin
                            m_data_reg  <= rw_data;
                            m_keep_reg  <= s_axis.tkeep;
                            m_user_reg  <= s_axis.tuser;
                            m_last_reg  <= s_axis.tlast;
                            m_valid_reg <= 1'b1;
                            if (!s_axis.tlast) begin
                                state_reg <= ST_FWD;
                            end
                        end else if (!s_axis.tlast) begin
                            state_reg <= ST_DROP;
                        end
                    end
                    ST_FWD: begin
                        m_data_reg  <= s_axis.tdata;
                        m_keep_reg  <= s_axis.tkeep;
                        m_user_reg  <= s_axis.tuser;
                        m_last_reg  <= s_axis.tlast;
                        m_valid_reg <= 1'b1;
                        if (s_axis.tlast) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (s_axis.tlast) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid_reg;
    assign m_axis.tlast  = m_last_reg;
    assign m_axis.tdata  = m_data_reg;
    assign m_axis.tkeep  = m_keep_reg;
    assign m_axis.tuser  = m_user_reg;

`ifdef RMT_TX_STATS_EN
    logic [31:0] stat_frames_reg;
    logic [31:0] stat_drops_reg;
    logic        drop_evt;
    logic        frame_evt;

    assign drop_evt  = s_accept && (state_reg == ST_IDLE) && !first_ok;
    assign frame_evt = m_valid_reg && m_axis.tready && m_last_reg;

    // Saturating frame and drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames_reg <= 32'd0;
            stat_drops_reg  <= 32'd0;
        end else begin
            if (frame_evt && (stat_frames_reg != 32'hFFFF_FFFF)) begin
                stat_frames_reg <= stat_frames_reg + 32'd1;
            end
            if (drop_evt && (stat_drops_reg != 32'hFFFF_FFFF)) begin
                stat_drops_reg <= stat_drops_reg + 32'd1;
            end
        end
    end

    assign stat_frames = stat_frames_reg;
    assign stat_drops  = stat_drops_reg;
`else
    assign stat_frames = 32'd0;
    assign stat_drops  = 32'd0;
`endif

endmodule

// File: tb/tb_rmt_tx_deparser.sv
// Directed bench for rmt_tx_deparser: expected output beats are queued as
// stimulus is driven and compared by a monitor as the DUT emits them.
module tb_rmt_tx_deparser;

`ifdef RMT_TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [47:0] MAC_A = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_B = 48'h02_00_00_00_00_02;
    localparam logic [31:0] IP_A  = 32'h0A_00_00_01;
    localparam logic [31:0] IP_B  = 32'h0A_00_00_02;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [7:0]   user;
        logic         last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [15:0] s_tid;
    logic [31:0] stat_frames;
    logic [31:0] stat_drops;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_frames = 32'd0;
    logic [31:0] exp_drops  = 32'd0;
    beat_t exp_q[$];

    rmt_tx_deparser_if #(.DATA_WIDTH(512), .KEEP_WIDTH(64), .USER_WIDTH(8)) s_if ();
    rmt_tx_deparser_if #(.DATA_WIDTH(512), .KEEP_WIDTH(64), .USER_WIDTH(8)) m_if ();

    rmt_tx_deparser #(.DATA_WIDTH(512), .KEEP_WIDTH(64), .USER_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_if),
        .s_axis_tid (s_tid),
        .m_axis     (m_if),
        .stat_frames(stat_frames),
        .stat_drops (stat_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Body beat that can never look like a valid header.
    function automatic logic [511:0] body();
        logic [511:0] r;
        r = rnd512();
        r[42*8 +: 16] = 16'h0000;
        return r;
    endfunction

    // Header builder in network byte order from field values.
    function automatic logic [511:0] hdr(input logic [47:0] dst, input logic [47:0] src,
                                         input logic [31:0] sip, input logic [31:0] dip,
                                         input logic [15:0] sp, input logic [15:0] dp,
                                         input logic [15:0] cs, input logic [15:0] delim,
                                         input logic [15:0] f44, input logic [511:0] fill);
        logic [511:0] d;
        d = fill;
        for (int i = 0; i < 6; i++) begin
            d[i*8 +: 8]     = dst[(5-i)*8 +: 8];
            d[(6+i)*8 +: 8] = src[(5-i)*8 +: 8];
        end
        d[12*8 +: 16] = 16'h0008;
        for (int i = 0; i < 4; i++) begin
            d[(26+i)*8 +: 8] = sip[(3-i)*8 +: 8];
            d[(30+i)*8 +: 8] = dip[(3-i)*8 +: 8];
        end
        d[34*8 +: 8] = sp[15:8];
        d[35*8 +: 8] = sp[7:0];
        d[36*8 +: 8] = dp[15:8];
        d[37*8 +: 8] = dp[7:0];
        d[40*8 +: 8] = cs[15:8];
        d[41*8 +: 8] = cs[7:0];
        d[42*8 +: 16] = delim;
        d[44*8 +: 16] = f44;
        return d;
    endfunction

    // Monitor: every beat taken by the sink is compared against the queue head.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("out_tdata", m_if.tdata, e.data);
                chk("out_tkeep", m_if.tkeep, e.keep);
                chk("out_tuser", m_if.tuser, e.user);
                chk("out_tlast", m_if.tlast, e.last);
                $display("out beat last=%0d user=%02h checks=%0d", m_if.tlast, m_if.tuser, checks);
            end
        end
    end

    // Present one beat and wait (bounded) until it is accepted.
    task automatic send(input logic [511:0] d, input logic [63:0] k, input logic [7:0] u,
                        input logic l, input logic [15:0] tid, output int waits);
        bit acc;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        s_tid       = tid;
        waits = 0;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = s_if.tready;
            if (!acc) waits++;
        end
        if (!acc) chk("accept_timeout", waits, 0);
        @(posedge clk);
        #1;
    endtask

    // Send a frame; good frames queue their expected output beats.
    task automatic frame(input logic [511:0] din, input logic [511:0] dexp, input logic [63:0] k0,
                         input bit ok, input int nb, input logic [15:0] tid);
        for (int b = 0; b < nb; b++) begin
            logic [511:0] d;
            logic [63:0]  k;
            logic [7:0]   u;
            logic         l;
            int           w;
            beat_t        e;
            l = (b == nb - 1);
            if (b == 0) begin
                d = din;
                k = k0;
            end else begin
                d = body();
                k = l ? 64'h0000_00FF_FFFF_FFFF : '1;
            end
            u = 8'($urandom);
            if (ok) begin
                e.data = (b == 0) ? dexp : d;
                e.keep = k;
                e.user = u;
                e.last = l;
                exp_q.push_back(e);
            end
            send(d, k, u, l, tid, w);
            if (!ok) chk("drop_tready", w, 0);
        end
        s_if.tvalid = 1'b0;
        if (ok) exp_frames = sat_inc(exp_frames);
        else    exp_drops  = sat_inc(exp_drops);
        $display("frame sent ok=%0d beats=%0d tid=%04h", ok, nb, tid);
    endtask

    task automatic good_hdr(input logic [15:0] tid, input logic [15:0] delim,
                            output logic [511:0] din, output logic [511:0] dexp);
        logic [511:0] fill;
        fill = rnd512();
        din  = hdr(MAC_A, MAC_B, IP_A, IP_B, 16'd1234, 16'd5678, 16'hABCD, delim, 16'($urandom), fill);
        dexp = hdr(MAC_B, MAC_A, IP_B, IP_A, 16'd5678, 16'd1234, 16'h0000, delim, tid | 16'h8000, fill);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_frames"}, stat_frames, STATS ? exp_frames : 32'd0);
        chk({tag, "_drops"},  stat_drops,  STATS ? exp_drops  : 32'd0);
    endtask

    initial begin
        logic [511:0] din;
        logic [511:0] dexp;
        int w;

        rst = 1'b1;
        s_tid = 16'h0;
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tuser = '0;
        s_if.tlast = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", s_if.tready, 1'b0);
        chk("rst_m_tvalid", m_if.tvalid, 1'b0);
        chk("rst_m_tlast",  m_if.tlast, 1'b0);
        chk("rst_m_tdata",  m_if.tdata, '0);
        chk("rst_m_tkeep",  m_if.tkeep, '0);
        chk_stats("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_tready", s_if.tready, 1'b1);
        @(posedge clk);
        #1;

        // Single-beat frame, one cycle latency
        good_hdr(16'h0001, 16'hF0E1, din, dexp);
        frame(din, dexp, '1, 1'b1, 1, 16'h0001);
        chk("latency_m_tvalid", m_if.tvalid, 1'b1);
        chk("resp_flag", m_if.tdata[44*8 +: 16], 16'h8001);
        drain();
        chk_stats("single");

        // Three-beat frame with the sink stalled after beat 1
        m_if.tready = 1'b0;
        good_hdr(16'h0002, 16'hF0E1, din, dexp);
        exp_q.push_back('{data: dexp, keep: '1, user: 8'h11, last: 1'b0});
        send(din, '1, 8'h11, 1'b0, 16'h0002, w);
        begin
            logic [511:0] b2;
            logic [511:0] b3;
            b2 = body();
            b3 = body();
            s_if.tdata  = b2;
            s_if.tkeep  = '1;
            s_if.tuser  = 8'h22;
            s_if.tlast  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("stall_s_tready", s_if.tready, 1'b0);
                chk("stall_m_tvalid", m_if.tvalid, 1'b1);
                chk("stall_m_tdata",  m_if.tdata, dexp);
                chk("stall_m_tlast",  m_if.tlast, 1'b0);
            end
            @(posedge clk);
            #1;
            m_if.tready = 1'b1;
            exp_q.push_back('{data: b2, keep: '1, user: 8'h22, last: 1'b0});
            send(b2, '1, 8'h22, 1'b0, 16'h0002, w);
            exp_q.push_back('{data: b3, keep: 64'h0000_0000_0000_FFFF, user: 8'h33, last: 1'b1});
            send(b3, 64'h0000_0000_0000_FFFF, 8'h33, 1'b1, 16'h0002, w);
            s_if.tvalid = 1'b0;
            exp_frames = sat_inc(exp_frames);
        end
        drain();
        chk_stats("stall");

        // Bad delimiter: dropped, then a good frame right behind it
        good_hdr(16'h0003, 16'h1234, din, dexp);
        frame(din, dexp, '1, 1'b0, 3, 16'h0003);
        good_hdr(16'h0004, 16'hF0E1, din, dexp);
        frame(din, dexp, '1, 1'b1, 2, 16'h0004);
        drain();
        chk_stats("bad_delim");

        // Short first beat (44 bytes) is dropped
        good_hdr(16'h0005, 16'hF0E1, din, dexp);
        frame(din, dexp, 64'h0000_0FFF_FFFF_FFFF, 1'b0, 2, 16'h0005);
        drain();
        chk_stats("short_keep");

        // Idle bus with garbage data changes nothing
        s_if.tdata = rnd512();
        s_if.tlast = 1'b1;
        s_if.tvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_m_tvalid", m_if.tvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        chk_stats("idle");

        // Tid already carrying the flag bit, single beat
        good_hdr(16'h8005, 16'hF0E1, din, dexp);
        frame(din, dexp, '1, 1'b1, 1, 16'h8005);
        drain();

        // Reset during beat 2 of a 4-beat frame
        good_hdr(16'h0006, 16'hF0E1, din, dexp);
        exp_q.push_back('{data: dexp, keep: '1, user: 8'h44, last: 1'b0});
        send(din, '1, 8'h44, 1'b0, 16'h0006, w);
        s_if.tdata = body();
        s_if.tkeep = '1;
        s_if.tlast = 1'b0;
        s_if.tvalid = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_s_tready", s_if.tready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_frames = 32'd0;
        exp_drops  = 32'd0;
        @(negedge clk);
        chk("midrst_m_tvalid", m_if.tvalid, 1'b0);
        chk_stats("midrst");
        // Remaining beats of the old frame now look like a malformed frame
        send(s_if.tdata, '1, 8'h55, 1'b0, 16'h0006, w);
        send(body(), '1, 8'h56, 1'b1, 16'h0006, w);
        s_if.tvalid = 1'b0;
        exp_drops = sat_inc(exp_drops);
        good_hdr(16'h0007, 16'hF0E1, din, dexp);
        frame(din, dexp, '1, 1'b1, 2, 16'h0007);
        drain();
        chk_stats("after_midrst");

        // Frame counter saturation
`ifdef RMT_TX_STATS_EN
        force dut.stat_frames_reg = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.stat_frames_reg;
        exp_frames = 32'hFFFF_FFFE;
`endif
        good_hdr(16'h0008, 16'hF0E1, din, dexp);
        frame(din, dexp, '1, 1'b1, 1, 16'h0008);
        good_hdr(16'h0009, 16'hF0E1, din, dexp);
        frame(din, dexp, '1, 1'b1, 2, 16'h0009);
        drain();
        chk_stats("saturate");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
